return_stack: RTL
=================

RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of return-address entries (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 12, return-address width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 resets).
REQ-005 SHALL have port push  input  1  JSB push request from the controller.
REQ-006 SHALL have port pop  input  1  RET pop request from the controller.
REQ-007 SHALL have port stall  input  1  pipeline hold; when 1, push/pop are ignored.
REQ-008 SHALL have port clear_err  input  1  synchronous clear of the sticky error flags.
REQ-009 SHALL have port push_addr  input  AW  return address (PC+1 of the JSB) to store.
REQ-010 SHALL have port top_addr  output  AW  current top entry, consumed by PC mux select 2'b11.
REQ-011 SHALL have port depth  output  $clog2(DEPTH)+1  number of valid entries.
REQ-012 SHALL have port empty  output  1  depth==0.
REQ-013 SHALL have port full  output  1  depth==DEPTH.
REQ-014 SHALL have port overflow  output  1  sticky: push attempted while full.
REQ-015 SHALL have port underflow  output  1  sticky: pop attempted while empty.

Function
REQ-016 SHALL hold a DEPTH x AW register array and a stack pointer sp (= depth); storage SHALL NOT be reset.
REQ-017 SHALL evaluate an operation only on a clock edge where stall=0; with stall=1 the array, sp and flags SHALL hold (clear_err still acts).
REQ-018 Push only, not full: SHALL write push_addr to entry[sp] and increment sp by 1.
REQ-019 Pop only, not empty: SHALL decrement sp by 1; entry contents unchanged.
REQ-020 Push only, full: SHALL leave array and sp unchanged and set overflow=1.
REQ-021 Pop only, empty: SHALL leave sp at 0 and set underflow=1.
REQ-022 Push and pop together, not empty: SHALL overwrite entry[sp-1] with push_addr; sp unchanged (replace top), no flag set, including when full.
REQ-023 Push and pop together, empty: SHALL behave as push only; underflow SHALL NOT be set.
REQ-024 top_addr SHALL be combinational from entry[sp-1] when sp>0, and all-zero when sp==0.
REQ-025 Latency: a push accepted at edge N SHALL be visible on top_addr, depth, full/empty immediately after edge N (same cycle as new sp); a pop at edge N SHALL expose the previous entry after edge N.
REQ-026 sp arithmetic SHALL never wrap: it saturates at 0 and DEPTH by REQ-020/021.
REQ-027 clear_err=1 SHALL clear overflow and underflow at the edge; if a new error occurs on the same edge, the flag SHALL read 1 (set wins).
REQ-028 empty, full, depth SHALL be pure decodes of sp with no added latency.

Reset
REQ-029 reset=0 SHALL immediately, independent of clk, force sp=0, overflow=0, underflow=0; hence depth=0, empty=1, full=0, top_addr=0.
REQ-030 Reset asserted mid-operation SHALL discard any push/pop of that cycle; first operation is accepted at the first rising edge with reset=1.
REQ-031 Entry contents after reset are don't-care and SHALL never be observable because top_addr is 0 while empty.

Verification
REQ-032 Reset, push 0x0A1, 0x0B2, 0x0C3 -> top_addr 0x0C3, depth 3; pop x3 -> top_addr 0x0B2, 0x0A1, 0x000; empty=1, underflow=0.
REQ-033 Push 9 values 0x100..0x108 with DEPTH=8 -> full=1 after 8th, 9th ignored, overflow=1, top_addr=0x107; clear_err -> overflow=0.
REQ-034 From empty, pop -> underflow=1, depth 0, top_addr 0; then push+pop together with push_addr=0x055 -> depth 1, top_addr 0x055, underflow still 1.
REQ-035 Depth 2 (0x011,0x022), push+pop with 0x033 -> depth 2, top_addr 0x033; pop -> top_addr 0x011.
REQ-036 stall=1 with push=1 for 3 cycles -> depth unchanged; drop reset to 0 between edges at depth 4 -> depth 0, empty=1 before next edge.

Source files
------------

// File: rtl/return_stack.sv
// Subroutine return-address stack: push on JSB, pop on RET, replace-top on simultaneous push/pop.
// Storage is not reset; top_addr reads zero whenever the stack is empty so stale entries never leak.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       stall,
  input  logic                       clear_err,
  input  logic [AW-1:0]              push_addr,
  output logic [AW-1:0]              top_addr,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int SPW = $clog2(DEPTH) + 1;
  localparam int IW  = $clog2(DEPTH);

  logic [AW-1:0]  mem [DEPTH];
  logic [SPW-1:0] sp, sp_nxt;
  logic [IW-1:0]  top_idx, wr_idx;
  logic           wr_en, set_ovf, set_unf;

  assign empty   = (sp == '0);
  assign full    = (sp == SPW'(DEPTH));
  assign depth   = sp;
  assign top_idx = IW'(sp - 1'b1);
  assign top_addr = empty ? '0 : mem[top_idx];

  // push+pop on an empty stack degrades to a plain push without flagging underflow
  always_comb begin
    sp_nxt  = sp;
    wr_en   = 1'b0;
    wr_idx  = IW'(sp);
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (!stall) begin
      unique case ({push, pop})
        2'b10: begin
          if (full) set_ovf = 1'b1;
          else begin
            wr_en  = 1'b1;
            sp_nxt = sp + 1'b1;
          end
        end
        2'b01: begin
          if (empty) set_unf = 1'b1;
          else       sp_nxt  = sp - 1'b1;
        end
        2'b11: begin
          wr_en = 1'b1;
          if (empty) sp_nxt = sp + 1'b1;
          else       wr_idx = top_idx;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_nxt;
      // a new error on the clearing edge wins over clear_err
      overflow  <= set_ovf | (overflow  & ~clear_err);
      underflow <= set_unf | (underflow & ~clear_err);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= push_addr;
  end
endmodule
